sm_divider_seq: RTL

Iterative sign-magnitude divider for the signed calculator datapath. It produces both quotient and remainder of two WIDTH-bit sign-magnitude operands using restoring division, one magnitude bit per cycle. A Start/Busy/Done handshake lets the calculator front end sequence it in place of the single-cycle remainder path. Remainder sign and divide-by-zero results match the existing remainder operation, so its results are a strict superset of that operation.

---
 rtl/sm_calc_pkg.sv | 54 +++++
 rtl/sm_div_step.sv | 32 +++
 rtl/sm_divider_seq.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/sm_calc_pkg.sv
// Shared definitions for the signed (sign-magnitude) calculator datapath:
// divider FSM state encoding, width helpers and sign-magnitude pack/unpack
// functions used by all signed calculator operations.
package sm_calc_pkg;

  // Divider sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIN  = 2'd2
  } sm_div_state_e;

  // Default operand width of the calculator datapath.
  localparam int SM_DEF_WIDTH = 8;

  // Helpers operate on a wide container so one set of functions serves every
  // operand width; callers widen on the way in and narrow on the way out.
  localparam int SM_MAX_W = 64;
  localparam logic [SM_MAX_W-1:0] SM_ONE = {{(SM_MAX_W-1){1'b0}}, 1'b1};

  // Bit position of the sign in a WIDTH-bit operand.
  function automatic int sm_sign_idx(input int width);
    return width - 1;
  endfunction

  // Number of magnitude bits in a WIDTH-bit operand.
  function automatic int sm_mag_w(input int width);
    return width - 1;
  endfunction

  // Unpack: sign bit of a WIDTH-bit operand.
  function automatic logic sm_sign(input logic [SM_MAX_W-1:0] v, input int width);
    return |(v & (SM_ONE << sm_sign_idx(width)));
  endfunction

  // Unpack: magnitude of a WIDTH-bit operand (sign and upper bits cleared).
  function automatic logic [SM_MAX_W-1:0] sm_mag(input logic [SM_MAX_W-1:0] v, input int width);
    return v & ((SM_ONE << sm_mag_w(width)) - SM_ONE);
  endfunction

  // Pack: build a WIDTH-bit operand from sign and magnitude.
  function automatic logic [SM_MAX_W-1:0] sm_pack(input logic sign,
                                                 input logic [SM_MAX_W-1:0] mag,
                                                 input int width);
    logic [SM_MAX_W-1:0] sbit;
    if (sign) begin
      sbit = SM_ONE << sm_sign_idx(width);
    end else begin
      sbit = {SM_MAX_W{1'b0}};
    end
    return sm_mag(mag, width) | sbit;
  endfunction

endpackage

// File: rtl/sm_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module sm_div_step
  import sm_calc_pkg::*;
#(
  parameter int PW = SM_DEF_WIDTH
) (
  input  logic [PW-1:0] p_in,
  input  logic [PW-1:0] divisor,
  input  logic          dvd_bit,
  output logic [PW-1:0] p_out,
  output logic          q_bit
);

  logic [PW:0]   shifted_s;
  logic [PW-1:0] diff_s;

  // Trial subtraction; the low PW bits of the difference are exact whenever
  // the subtraction is taken because the result is then below the divisor.
  always_comb begin
    shifted_s = {p_in, dvd_bit};
    diff_s    = shifted_s[PW-1:0] - divisor;
    if (shifted_s >= {1'b0, divisor}) begin
      p_out = diff_s;
      q_bit = 1'b1;
    end else begin
      p_out = shifted_s[PW-1:0];
      q_bit = 1'b0;
    end
  end

endmodule

// File: rtl/sm_divider_seq.sv
// Iterative sign-magnitude divider: restoring division, one magnitude bit
// per cycle, with a Start/Busy/Done handshake. Quotient sign is sA^sB,
// remainder sign is sA; a zero divisor yields zero magnitudes and DivZero.
module sm_divider_seq
  import sm_calc_pkg::*;
#(
  parameter int WIDTH = SM_DEF_WIDTH
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder
);

  localparam int MAG = sm_mag_w(WIDTH);
  localparam int CW  = $clog2(MAG + 1);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_CALC = ST_CALC;
  localparam logic [1:0] S_FIN  = ST_FIN;

  logic [1:0]       state_r;
  logic [CW-1:0]    cnt_r;
  logic [MAG:0]     p_r;        // partial remainder
  logic [MAG-1:0]   dq_r;       // dividend bits shift out the top, quotient bits shift in
  logic [MAG-1:0]   dvs_r;      // divisor magnitude
  logic             sa_r;
  logic             sb_r;
  logic             zero_r;     // current operation has a zero divisor
  logic             busy_r;
  logic             done_r;
  logic             divzero_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] rem_r;

  logic [SM_MAX_W-1:0] a_ext_s;
  logic [SM_MAX_W-1:0] b_ext_s;
  logic [MAG-1:0]      a_mag_s;
  logic [MAG-1:0]      b_mag_s;
  logic                a_sign_s;
  logic                b_sign_s;
  logic                b_zero_s;
  logic                last_s;
  logic [MAG:0]        p_nxt_s;
  logic                q_bit_s;
  logic [MAG-1:0]      q_mag_s;
  logic [MAG-1:0]      r_mag_s;
  logic [WIDTH-1:0]    quo_nxt_s;
  logic [WIDTH-1:0]    rem_nxt_s;

  sm_div_step #(
    .PW (MAG + 1)
  ) u_step (
    .p_in    (p_r),
    .divisor ({1'b0, dvs_r}),
    .dvd_bit (dq_r[MAG-1]),
    .p_out   (p_nxt_s),
    .q_bit   (q_bit_s)
  );

  // Operand unpacking and final result packing.
  always_comb begin
    a_ext_s  = SM_MAX_W'(A);
    b_ext_s  = SM_MAX_W'(B);
    a_mag_s  = MAG'(sm_mag(a_ext_s, WIDTH));
    b_mag_s  = MAG'(sm_mag(b_ext_s, WIDTH));
    a_sign_s = sm_sign(a_ext_s, WIDTH);
    b_sign_s = sm_sign(b_ext_s, WIDTH);
    b_zero_s = (b_mag_s == {MAG{1'b0}});
    last_s   = (cnt_r == CW'(1));
    if (zero_r) begin
      q_mag_s = {MAG{1'b0}};
      r_mag_s = {MAG{1'b0}};
    end else begin
      q_mag_s = {dq_r[MAG-2:0], q_bit_s};
      r_mag_s = p_nxt_s[MAG-1:0];
    end
    quo_nxt_s = WIDTH'(sm_pack(sa_r ^ sb_r, SM_MAX_W'(q_mag_s), WIDTH));
    rem_nxt_s = WIDTH'(sm_pack(sa_r, SM_MAX_W'(r_mag_s), WIDTH));
  end

  // FSM, iteration counter and result registers. A zero divisor spends a
  // single non-busy cycle in CALC so its Done lands one edge after the accept.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_r   <= S_IDLE;
      cnt_r     <= {CW{1'b0}};
      p_r       <= {(MAG+1){1'b0}};
      dq_r      <= {MAG{1'b0}};
      dvs_r     <= {MAG{1'b0}};
      sa_r      <= 1'b0;
      sb_r      <= 1'b0;
      zero_r    <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      divzero_r <= 1'b0;
      quo_r     <= {WIDTH{1'b0}};
      rem_r     <= {WIDTH{1'b0}};
    end else begin
      done_r <= 1'b0;
      case (state_r)
        S_IDLE, S_FIN: begin
          if (Start) begin
            sa_r   <= a_sign_s;
            sb_r   <= b_sign_s;
            dq_r   <= a_mag_s;
            dvs_r  <= b_mag_s;
            p_r    <= {(MAG+1){1'b0}};
            zero_r <= b_zero_s;
            state_r <= S_CALC;
            if (b_zero_s) begin
              cnt_r  <= CW'(1);
              busy_r <= 1'b0;
            end else begin
              cnt_r     <= CW'(MAG);
              busy_r    <= 1'b1;
              divzero_r <= 1'b0;
            end
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_CALC: begin
          p_r   <= p_nxt_s;
          dq_r  <= {dq_r[MAG-2:0], q_bit_s};
          cnt_r <= cnt_r - CW'(1);
          if (last_s) begin
            state_r   <= S_FIN;
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
            divzero_r <= zero_r;
            quo_r     <= quo_nxt_s;
            rem_r     <= rem_nxt_s;
          end else begin
            state_r <= S_CALC;
          end
        end
        default: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign Busy      = busy_r;
  assign Done      = done_r;
  assign DivZero   = divzero_r;
  assign Quotient  = quo_r;
  assign Remainder = rem_r;

endmodule
